// File: rtl/sha_word_fifo_ctrl.sv
// sha_word_fifo_ctrl
// Ready/valid FIFO controller for an external 1R/1W asynchronous-read RAM.
// Holds only the write/read pointers and the occupancy count. Word storage
// lives in the RAM, and this block drives all of the RAM addressing.
//
// Ports:
//   clk_i, reset_n_i         clock, synchronous active-low reset
//   v_i, data_i, ready_o     upstream word interface (valid/ready)
//   v_o, data_o, yumi_i      downstream head-word interface (valid/yumi)
//   mem_w_v_o, mem_w_addr_o,
//   mem_w_data_o             RAM write port
//   mem_r_addr_o,
//   mem_r_data_i             RAM asynchronous read port
//   count_o                  occupancy, 0..els_p
//   full_o, empty_o,
//   almost_full_o            status flags, decoded from the occupancy count
module sha_word_fifo_ctrl #(
    parameter int unsigned width_p              = 32,
    parameter int unsigned els_p                = 16,
    parameter int unsigned almost_full_thresh_p = els_p - 2,
    // Derived widths; do not override.
    parameter int unsigned addr_width_lp        = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int unsigned count_width_lp       = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,

    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,

    output logic                      mem_w_v_o,
    output logic [addr_width_lp-1:0]  mem_w_addr_o,
    output logic [width_p-1:0]        mem_w_data_o,
    output logic [addr_width_lp-1:0]  mem_r_addr_o,
    input  logic [width_p-1:0]        mem_r_data_i,

    output logic [count_width_lp-1:0] count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      almost_full_o
);

    localparam logic [addr_width_lp-1:0]  last_addr_lp = addr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] els_cnt_lp   = count_width_lp'(els_p);
    localparam logic [count_width_lp-1:0] af_cnt_lp    = count_width_lp'(almost_full_thresh_p);

    logic [addr_width_lp-1:0]  wptr_r, wptr_n;
    logic [addr_width_lp-1:0]  rptr_r, rptr_n;
    logic [count_width_lp-1:0] count_r, count_n;
    logic                      enq, deq;

    // Status decode: flags depend only on the registered count
    assign empty_o       = (count_r == '0);
    assign full_o        = (count_r == els_cnt_lp);
    assign almost_full_o = (count_r >= af_cnt_lp);
    assign count_o       = count_r;

    // Handshakes are gated by reset so nothing moves while reset is held low
    assign ready_o = reset_n_i & ~full_o;
    assign v_o     = reset_n_i & ~empty_o;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // RAM port wiring; the read data is the head word with no bypass path
    assign mem_w_v_o    = enq;
    assign mem_w_addr_o = wptr_r;
    assign mem_w_data_o = data_i;
    assign mem_r_addr_o = rptr_r;
    assign data_o       = mem_r_data_i;

    // Next pointers and count; the explicit wrap compare supports any depth
    always_comb begin
        wptr_n  = wptr_r;
        rptr_n  = rptr_r;
        count_n = count_r;

        if (enq) begin
            wptr_n = (wptr_r == last_addr_lp) ? '0 : wptr_r + addr_width_lp'(1);
        end
        if (deq) begin
            rptr_n = (rptr_r == last_addr_lp) ? '0 : rptr_r + addr_width_lp'(1);
        end

        unique case ({enq, deq})
            2'b10:   count_n = count_r + count_width_lp'(1);
            2'b01:   count_n = count_r - count_width_lp'(1);
            default: count_n = count_r;
        endcase
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            wptr_r  <= wptr_n;
            rptr_r  <= rptr_n;
            count_r <= count_n;
        end
    end

endmodule

// File: tb/tb_sha_word_fifo_ctrl.sv
// Testbench for sha_word_fifo_ctrl: a depth-4 instance (a) and a depth-5 instance (b),
// each backed by an asynchronous-read RAM model, with scoreboard queues of expected words.
module tb_sha_word_fifo_ctrl;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: els_p = 4, thresh = 2
    logic        a_v_i, a_ready, a_v_o, a_yumi, a_mw_v, a_full, a_empty, a_af;
    logic [31:0] a_data_i, a_data_o, a_mw_data, a_mr_data;
    logic [1:0]  a_mw_addr, a_mr_addr;
    logic [2:0]  a_count;

    // Instance b: els_p = 5, thresh = 3
    logic        b_v_i, b_ready, b_v_o, b_yumi, b_mw_v, b_full, b_empty, b_af;
    logic [31:0] b_data_i, b_data_o, b_mw_data, b_mr_data;
    logic [2:0]  b_mw_addr, b_mr_addr;
    logic [2:0]  b_count;

    logic [31:0] mem_a [0:3];
    logic [31:0] mem_b [0:7];

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    sha_word_fifo_ctrl #(.width_p(32), .els_p(4)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .v_i(a_v_i), .data_i(a_data_i), .ready_o(a_ready),
        .v_o(a_v_o), .data_o(a_data_o), .yumi_i(a_yumi),
        .mem_w_v_o(a_mw_v), .mem_w_addr_o(a_mw_addr), .mem_w_data_o(a_mw_data),
        .mem_r_addr_o(a_mr_addr), .mem_r_data_i(a_mr_data),
        .count_o(a_count), .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af)
    );

    sha_word_fifo_ctrl #(.width_p(32), .els_p(5)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .v_i(b_v_i), .data_i(b_data_i), .ready_o(b_ready),
        .v_o(b_v_o), .data_o(b_data_o), .yumi_i(b_yumi),
        .mem_w_v_o(b_mw_v), .mem_w_addr_o(b_mw_addr), .mem_w_data_o(b_mw_data),
        .mem_r_addr_o(b_mr_addr), .mem_r_data_i(b_mr_data),
        .count_o(b_count), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af)
    );

    // Asynchronous-read RAM models
    always @(posedge clk) begin
        if (a_mw_v) mem_a[a_mw_addr] <= a_mw_data;
        if (b_mw_v) mem_b[b_mw_addr] <= b_mw_data;
    end
    assign a_mr_data = mem_a[a_mr_addr];
    assign b_mr_data = mem_b[b_mr_addr];

    function automatic logic [31:0] pop_a();
        if (q_a.size() == 0) return 'x;
        return q_a.pop_front();
    endfunction

    function automatic logic [31:0] pop_b();
        if (q_b.size() == 0) return 'x;
        return q_b.pop_front();
    endfunction

    // Drive inputs after the falling edge, then settle so outputs can be sampled
    task automatic drive_a(input logic v, input logic [31:0] d, input logic y);
        @(negedge clk);
        a_v_i = v; a_data_i = d; a_yumi = y;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] d, input logic y);
        @(negedge clk);
        b_v_i = v; b_data_i = d; b_yumi = y;
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] got, exp;
        drive_a(1'b1, 32'hDEAD_BEEF, 1'b1);
        got = 64'({a_ready, a_v_o, a_mw_v});
        exp = 64'(3'b000);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_low_handshake: got %h expected %h", got, exp);
        end
        @(negedge clk);
        rst_n = 1'b1; a_v_i = 1'b0; a_yumi = 1'b0;
        #1;
        got = 64'({a_count, a_empty, a_full, a_af, a_ready, a_v_o});
        exp = 64'({3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_release_a: got %h expected %h", got, exp);
        end
        got = 64'({b_count, b_empty, b_full, b_ready, b_v_o});
        exp = 64'({3'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_release_b: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_fill();
        logic [63:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'hA0 + 32'(i), 1'b0);
            got = 64'({a_mw_v, a_mw_addr, a_ready, a_count, a_af});
            exp = 64'({1'b1, 2'(i), 1'b1, 3'(i), 1'(i >= 2)});
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL fill_%0d: got %h expected %h", i, got, exp);
            end
            q_a.push_back(32'hA0 + 32'(i));
        end
        drive_a(1'b1, 32'hA4, 1'b0);
        got = 64'({a_mw_v, a_ready, a_full, a_count, a_af});
        exp = 64'({1'b0, 1'b0, 1'b1, 3'd4, 1'b1});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL fill_full_block: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_drain();
        logic [63:0] got, exp;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 32'h0, 1'b1);
            w   = pop_a();
            got = 64'({a_v_o, a_data_o, a_count});
            exp = 64'({1'b1, w, 3'(4 - i)});
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL drain_%0d: got %h expected %h", i, got, exp);
            end
        end
        drive_a(1'b0, 32'h0, 1'b0);
        got = 64'({a_empty, a_v_o, a_count});
        exp = 64'({1'b1, 1'b0, 3'd0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL drain_empty: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_empty_write();
        logic [63:0] got, exp;
        logic [31:0] w;
        drive_a(1'b1, 32'h55, 1'b1);
        got = 64'({a_v_o, a_mw_v, a_count});
        exp = 64'({1'b0, 1'b1, 3'd0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL empty_no_bypass: got %h expected %h", got, exp);
        end
        q_a.push_back(32'h55);
        drive_a(1'b0, 32'h0, 1'b1);
        w   = pop_a();
        got = 64'({a_v_o, a_data_o, a_count});
        exp = 64'({1'b1, w, 3'd1});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL empty_next_cycle: got %h expected %h", got, exp);
        end
        drive_a(1'b0, 32'h0, 1'b1);
        got = 64'({a_v_o, a_count});
        exp = 64'({1'b0, 3'd0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL spurious_yumi_cycle: got %h expected %h", got, exp);
        end
        drive_a(1'b0, 32'h0, 1'b0);
        got = 64'({a_count, a_empty});
        exp = 64'({3'd0, 1'b1});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL spurious_yumi_after: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        logic [31:0] w;
        drive_a(1'b1, 32'hB0, 1'b0); q_a.push_back(32'hB0);
        drive_a(1'b1, 32'hB1, 1'b0); q_a.push_back(32'hB1);
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 32'hC0 + 32'(i), 1'b1);
            w   = pop_a();
            got = 64'({a_count, a_mw_v, a_ready, a_v_o, a_data_o});
            exp = 64'({3'd2, 1'b1, 1'b1, 1'b1, w});
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_%0d: got %h expected %h", i, got, exp);
            end
            q_a.push_back(32'hC0 + 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 32'h0, 1'b1);
            w   = pop_a();
            got = 64'({a_v_o, a_data_o});
            exp = 64'({1'b1, w});
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_tail_%0d: got %h expected %h", i, got, exp);
            end
        end
        // Full with yumi: no pass-through, freed slot usable next cycle
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'hD0 + 32'(i), 1'b0);
            q_a.push_back(32'hD0 + 32'(i));
        end
        drive_a(1'b1, 32'hE0, 1'b1);
        w   = pop_a();
        got = 64'({a_ready, a_mw_v, a_full, a_data_o});
        exp = 64'({1'b0, 1'b0, 1'b1, w});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL full_yumi_same: got %h expected %h", got, exp);
        end
        drive_a(1'b1, 32'hE1, 1'b0);
        got = 64'({a_count, a_ready, a_mw_v});
        exp = 64'({3'd3, 1'b1, 1'b1});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL full_yumi_next: got %h expected %h", got, exp);
        end
        q_a.push_back(32'hE1);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 32'h0, 1'b1);
            w   = pop_a();
            got = 64'({a_v_o, a_data_o});
            exp = 64'({1'b1, w});
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL full_drain_%0d: got %h expected %h", i, got, exp);
            end
        end
        drive_a(1'b0, 32'h0, 1'b0);
        checks++;
        if (a_empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_final_empty: got %b expected 1", a_empty);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] got, exp;
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 32'hF0 + 32'(i), 1'b0);
            q_a.push_back(32'hF0 + 32'(i));
        end
        @(negedge clk);
        rst_n = 1'b0; a_v_i = 1'b1; a_data_i = 32'hFF; a_yumi = 1'b0;
        #1;
        got = 64'({a_count, a_ready, a_v_o, a_mw_v});
        exp = 64'({3'd3, 1'b0, 1'b0, 1'b0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_reset_low: got %h expected %h", got, exp);
        end
        @(negedge clk);
        #1;
        got = 64'({a_count, a_ready, a_v_o, a_empty});
        exp = 64'({3'd0, 1'b0, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_reset_cleared: got %h expected %h", got, exp);
        end
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1; a_v_i = 1'b1; a_data_i = 32'h123; a_yumi = 1'b0;
        #1;
        got = 64'({a_mw_v, a_mw_addr, a_ready});
        exp = 64'({1'b1, 2'd0, 1'b1});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_reset_first_enq: got %h expected %h", got, exp);
        end
        q_a.push_back(32'h123);
        drive_a(1'b0, 32'h0, 1'b1);
        w   = pop_a();
        got = 64'({a_v_o, a_data_o, a_mr_addr});
        exp = 64'({1'b1, w, 2'd0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL mid_reset_readback: got %h expected %h", got, exp);
        end
        drive_a(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [63:0] got, exp;
        logic [31:0] w;
        int bw = 0;
        int br = 0;
        drive_b(1'b1, 32'd100, 1'b0);
        got = 64'({b_mw_v, b_mw_addr});
        exp = 64'({1'b1, 3'(bw)});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL wrap_prime: got %h expected %h", got, exp);
        end
        q_b.push_back(32'd100);
        bw = 1;
        for (int i = 0; i < 12; i++) begin
            drive_b(1'b1, 32'd101 + 32'(i), 1'b1);
            w   = pop_b();
            got = 64'({b_mw_v, b_mw_addr, b_mr_addr, b_count, b_data_o});
            exp = 64'({1'b1, 3'(bw), 3'(br), 3'd1, w});
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL wrap_%0d: got %h expected %h", i, got, exp);
            end
            q_b.push_back(32'd101 + 32'(i));
            bw = (bw == 4) ? 0 : bw + 1;
            br = (br == 4) ? 0 : br + 1;
        end
        drive_b(1'b0, 32'h0, 1'b1);
        w   = pop_b();
        got = 64'({b_v_o, b_mr_addr, b_data_o});
        exp = 64'({1'b1, 3'(br), w});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL wrap_last: got %h expected %h", got, exp);
        end
        drive_b(1'b0, 32'h0, 1'b0);
        got = 64'({b_empty, b_count});
        exp = 64'({1'b1, 3'd0});
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL wrap_empty: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_v_i = 1'b0; a_data_i = '0; a_yumi = 1'b0;
        b_v_i = 1'b0; b_data_i = '0; b_yumi = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_empty_write();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha_word_fifo_ctrl.md
# sha_word_fifo_ctrl

Ready/valid FIFO controller that sits directly upstream of the team's 1-read/1-write asynchronous-read RAM and owns all of its addressing. It accepts message words from the SHA-256 input path, drives the RAM write port and read address, and presents the head word to the downstream consumer with valid/yumi semantics. Storage lives entirely in the external RAM; this block holds only pointers, occupancy and flags.

## Interface
- `width_p`, 32, word width in bits.
- `els_p`, 16, RAM depth in words; any integer ≥ 2, not required to be a power of two.
- `almost_full_thresh_p`, `els_p-2`, occupancy at or above which `almost_full_o` asserts; range 1..`els_p`.
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`, derived; do not override.
- `count_width_lp`, `BSG_SAFE_CLOG2(els_p+1)`, derived; do not override.

- `clk_i` in 1: single clock; all state updates on the rising edge.
- `reset_n_i` in 1: reset, synchronous and active-low.
- `v_i` in 1: upstream word valid.
- `data_i` in `width_p`: upstream word.
- `ready_o` out 1: block can accept a word this cycle.
- `v_o` out 1: head word valid.
- `data_o` out `width_p`: head word, equal to `mem_r_data_i`.
- `yumi_i` in 1: consumer takes head word this cycle; legal only when `v_o`=1.
- `mem_w_v_o` out 1: RAM write enable.
- `mem_w_addr_o` out `addr_width_lp`: RAM write address (write pointer).
- `mem_w_data_o` out `width_p`: RAM write data, equal to `data_i`.
- `mem_r_addr_o` out `addr_width_lp`: RAM read address (read pointer).
- `mem_r_data_i` in `width_p`: RAM asynchronous read data.
- `count_o` out `count_width_lp`: current occupancy, 0..`els_p`.
- `full_o`, `empty_o`, `almost_full_o` out 1 each: status flags.

## Operation
- Registered state: `wptr_r`, `rptr_r` (`addr_width_lp`), `count_r` (`count_width_lp`). All flags derive combinationally from `count_r`.
- `empty_o` = (`count_r`==0); `full_o` = (`count_r`==`els_p`); `almost_full_o` = (`count_r` ≥ `almost_full_thresh_p`).
- `ready_o` = `reset_n_i` & ~`full_o`. `v_o` = `reset_n_i` & ~`empty_o`.
- Enqueue `enq` = `v_i` & `ready_o`. Dequeue `deq` = `yumi_i` & `v_o`; `yumi_i` while `v_o`=0 is ignored with no state change.
- `mem_w_v_o` = `enq`. `mem_w_addr_o` = `wptr_r`. `mem_r_addr_o` = `rptr_r`.
- On `enq`: `wptr_r` advances by 1, wrapping from `els_p-1` to 0 (explicit compare, not modular truncation). On `deq`: `rptr_r` likewise.
- `count_r` += `enq` − `deq`; simultaneous `enq` and `deq` leave `count_r` unchanged while both pointers advance.
- Full with `yumi_i`: `ready_o` stays 0 that cycle (no same-cycle pass-through); the freed slot is enqueueable next cycle.
- Empty with `v_i`: no bypass; word is written to RAM and appears on `data_o` the following cycle.
- Reset (`reset_n_i`=0 at a rising edge): `wptr_r`=0, `rptr_r`=0, `count_r`=0. While low, `ready_o`=0, `v_o`=0, `mem_w_v_o`=0; in-flight words are discarded. After release: `count_o`=0, `empty_o`=1, `full_o`=0, `almost_full_o`=0 (unless thresh is 0, disallowed), `ready_o`=1.

## Timing
- Enqueue-to-`v_o` latency: 1 cycle (write at edge N, visible from cycle N+1 via async read).
- Dequeue: `yumi_i` at cycle N, next word (if any) on `data_o` in cycle N+1.
- Sustained throughput 1 word/cycle with concurrent enq/deq at any occupancy 1..`els_p-1`.
- Status outputs, `ready_o`, `v_o` change only after a clock edge or `reset_n_i` change; no combinational path from `v_i`/`yumi_i` to `ready_o`/`v_o`.

## Test plan
- Reset then fill: `els_p`=4, enqueue 0xA0..0xA3 on consecutive cycles -> `mem_w_addr_o` 0,1,2,3; `count_o` 1..4; `full_o`=1 and `ready_o`=0 after 4th; 5th `v_i` not written (`mem_w_v_o`=0).
- Drain in order: from full, hold `yumi_i`=1 -> `data_o` 0xA0,0xA1,0xA2,0xA3 on successive cycles; `empty_o`=1, `v_o`=0 after 4th.
- Non-power-of-two wrap: `els_p`=5, 12 enq/deq pairs -> pointers sequence 0,1,2,3,4,0,1…; data returned in order; `mem_w_addr_o` never reaches 5..7.
- Simultaneous enq/deq at occupancy 2 for 10 cycles -> `count_o` constant 2, output stream matches input stream delayed by 2 words; full + `yumi_i` -> `ready_o`=0 that cycle, 1 next.
- Empty + `v_i`=1 data 0x55 -> `v_o`=0 same cycle, `v_o`=1, `data_o`=0x55 next cycle; spurious `yumi_i` while empty -> `count_o` stays 0.
- Mid-operation reset at `count_o`=3 -> next cycle `count_o`=0, `v_o`=0, `ready_o`=0 while low; after release first enqueue written at address 0.
